// File: rtl/fp_add_arb_pkg.sv
// rtl/fp_add_arb_pkg.sv - shared types for the FP adder arbiter
package fp_add_arb_pkg;
    localparam int FP_WIDTH = 32;
    localparam int ID_W     = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } fp_tag_t;

    typedef struct packed {
        logic [FP_WIDTH-1:0] data;
        logic [ID_W-1:0]     id;
    } fp_res_t;
endpackage

// File: rtl/FPAdd32.sv
// rtl/FPAdd32.sv - fixed-latency single-precision adder core, round-to-nearest-even
module FPAdd32 #(
    parameter int LATENCY = 14
) (
    input  logic        clock,
    input  logic        go,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done
);
    logic [31:0]        data_pipe [LATENCY];
    logic [LATENCY-1:0] go_pipe;

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [7:0]  e_hi, e_lo;
        logic [26:0] m_hi, m_lo, m_al;
        logic [27:0] sum;
        logic [9:0]  exp;
        logic [24:0] rnd;
        logic        found, rup;
        int          d, lz;
        if (x[30:0] >= y[30:0]) begin
            hi = x; lo = y;
        end else begin
            hi = y; lo = x;
        end
        if (hi[30:23] == 8'hFF) return hi;
        // subnormals share the minimum exponent with a zero hidden bit
        e_hi = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
        e_lo = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
        m_hi = {|hi[30:23], hi[22:0], 3'b000};
        m_lo = {|lo[30:23], lo[22:0], 3'b000};
        d = int'(e_hi - e_lo);
        if (d > 26) begin
            m_al = {26'd0, |m_lo};
        end else begin
            m_al = m_lo >> d;
            m_al[0] = m_al[0] | (|(m_lo & ((27'd1 << d) - 27'd1)));
        end
        sum = (hi[31] ^ lo[31]) ? ({1'b0, m_hi} - {1'b0, m_al}) : ({1'b0, m_hi} + {1'b0, m_al});
        if (sum == 28'd0) return {hi[31] & lo[31], 31'd0};
        exp = {2'b00, e_hi};
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            exp = exp + 10'd1;
        end else begin
            found = 1'b0;
            lz = 0;
            for (int i = 26; i >= 0; i--) begin
                if (!found && !sum[i]) lz++;
                else found = 1'b1;
            end
            if (lz > int'(exp) - 1) lz = int'(exp) - 1;
            sum = sum << lz;
            exp = exp - 10'(lz);
        end
        rup = sum[2] & (sum[1] | sum[0] | sum[3]);
        rnd = {1'b0, sum[26:3]} + {24'd0, rup};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            exp = exp + 10'd1;
        end
        if (exp >= 10'd255) return {hi[31], 8'hFF, 23'd0};
        return {hi[31], rnd[23] ? exp[7:0] : 8'd0, rnd[22:0]};
    endfunction

    // the go chain is deliberately not reset; completion tracking lives outside
    always_ff @(posedge clock) begin
        data_pipe[0] <= fp_add(a, b);
        go_pipe[0]   <= go;
        for (int i = 1; i < LATENCY; i++) begin
            data_pipe[i] <= data_pipe[i-1];
            go_pipe[i]   <= go_pipe[i-1];
        end
    end

    assign result = data_pipe[LATENCY-1];
    assign done   = go_pipe[LATENCY-1];
endmodule

// File: rtl/fp_result_fifo.sv
// rtl/fp_result_fifo.sv - first-word-fall-through result FIFO with occupancy count
module fp_result_fifo
    import fp_add_arb_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  fp_res_t push_data,
    input  logic    pop,
    output fp_res_t pop_data,
    output logic    empty,
    output logic [AW:0] count
);
    fp_res_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (count != (AW+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin, credit-limited sharing of one FP adder core
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  LATENCY    = 14,
    parameter int  FIFO_DEPTH = 16,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);
    localparam int IFW  = $clog2(LATENCY + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW   = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    logic [IDW-1:0]  rr_ptr, grant_id;
    logic            grant_any, has_credit, issue;
    logic [IFW-1:0]  inflight;
    logic [CNTW-1:0] fifo_count;
    logic [CW-1:0]   used;
    logic            fifo_empty, core_done;
    logic [31:0]     core_result;
    fp_tag_t         tag_pipe [LATENCY];
    fp_tag_t         tag_out;
    fp_res_t         res_head;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_id  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // entries already committed: queued in the FIFO plus those still in the core
    assign used       = CW'(fifo_count) + CW'(inflight);
    assign has_credit = used < CW'(FIFO_DEPTH);
    assign issue      = grant_any && has_credit && !reset;
    assign req_ready  = issue ? (NUM_REQ'(1) << grant_id) : '0;
    assign tag_out    = tag_pipe[LATENCY-1];

    FPAdd32 #(.LATENCY(LATENCY)) u_core (
        .clock  (clock),
        .go     (issue),
        .a      (req_a[int'(grant_id)*FP_WIDTH +: FP_WIDTH]),
        .b      (req_b[int'(grant_id)*FP_WIDTH +: FP_WIDTH]),
        .result (core_result),
        .done   (core_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            inflight <= '0;
            for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            if (issue)
                rr_ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + IDW'(1);
            case ({issue, tag_out.valid})
                2'b10:   inflight <= inflight + IFW'(1);
                2'b01:   inflight <= inflight - IFW'(1);
                default: ;
            endcase
            tag_pipe[0].valid <= issue;
            tag_pipe[0].id    <= ID_W'(grant_id);
            for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    fp_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_out.valid),
        .push_data ('{data: core_result, id: tag_out.id}),
        .pop       (res_ready),
        .pop_data  (res_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = res_head.data;
    assign res_id    = res_head.id[IDW-1:0];
    assign busy      = (inflight != '0) || !fifo_empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!tag_out.valid || core_done);
            assert (fifo_empty || int'(res_head.id) < NUM_REQ);
        end
    end
endmodule
